// File: rtl/pc_npc_sequencer.sv
// pc_npc_sequencer: architectural PC/nPC pair with SPARC delayed-control-transfer
// sequencing (sequential step, Bicc with annul bit, jmpl, trap entry, and a
// sticky halt on misaligned control-transfer targets).
//
// Handshake: there is no valid/ready pair here. 'advance' is a single-cycle
// qualifier meaning "the instruction at pc_out retires this cycle"; the pair
// steps on the rising edge where advance=1, and every update shows up on
// pc_out/npc_out the cycle after that edge. Outputs depend only on registers.
module pc_npc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        br_always,
    input  logic        br_annul,
    input  logic [31:0] br_target,
    input  logic        jmpl_valid,
    input  logic [31:0] jmpl_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    output logic [31:0] pc_out,
    output logic [31:0] npc_out,
    output logic        annul_slot,
    output logic        trap_ack,
    output logic        misalign,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ANNUL = 2'd1,
        ST_TRAP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic        mis_q, mis_d;
    logic        br_eff_taken;

    // Bicc is taken when the condition holds or when it is branch-always.
    assign br_eff_taken = br_taken | br_always;

    // State and architectural registers; reset overrides any pending event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_NPC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            mis_q   <= mis_d;
        end
    end

    // Next-state and next PC/nPC selection: trap > jmpl > branch > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        mis_d   = mis_q;
        unique case (state_q)
            ST_RUN: begin
                if (trap_req) begin
                    pc_d    = trap_vec;
                    npc_d   = trap_vec + 32'd4;
                    state_d = ST_TRAP;
                end else if (advance) begin
                    if (jmpl_valid) begin
                        if (jmpl_target[1:0] != 2'b00) begin
                            state_d = ST_HALT;
                            mis_d   = 1'b1;
                        end else begin
                            pc_d  = npc_q;
                            npc_d = jmpl_target;
                        end
                    end else if (br_valid) begin
                        if (br_eff_taken && (br_target[1:0] != 2'b00)) begin
                            state_d = ST_HALT;
                            mis_d   = 1'b1;
                        end else begin
                            pc_d  = npc_q;
                            npc_d = br_eff_taken ? br_target : (npc_q + 32'd4);
                            // Annul the delay slot for untaken branches and for BA.
                            if (br_annul && (!br_eff_taken || br_always)) begin
                                state_d = ST_ANNUL;
                            end
                        end
                    end else begin
                        pc_d  = npc_q;
                        npc_d = npc_q + 32'd4;
                    end
                end
            end
            ST_ANNUL: begin
                if (trap_req) begin
                    pc_d    = trap_vec;
                    npc_d   = trap_vec + 32'd4;
                    state_d = ST_TRAP;
                end else if (advance) begin
                    // The squashed slot only steps; its control transfers are ignored.
                    pc_d    = npc_q;
                    npc_d   = npc_q + 32'd4;
                    state_d = ST_RUN;
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
            ST_HALT: begin
                if (trap_req) begin
                    pc_d    = trap_vec;
                    npc_d   = trap_vec + 32'd4;
                    state_d = ST_TRAP;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc_out     = pc_q;
    assign npc_out    = npc_q;
    assign annul_slot = (state_q == ST_ANNUL);
    assign trap_ack   = (state_q == ST_TRAP);
    assign misalign   = mis_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Directed testbench for pc_npc_sequencer.
module tb_pc_npc_sequencer;

    logic        clk;
    logic        reset;
    logic        advance;
    logic        br_valid;
    logic        br_taken;
    logic        br_always;
    logic        br_annul;
    logic [31:0] br_target;
    logic        jmpl_valid;
    logic [31:0] jmpl_target;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        annul_slot;
    logic        trap_ack;
    logic        misalign;
    logic [1:0]  state_out;

    int errors;
    int checks;

    // Observed bundle: pc, npc, state, annul_slot, trap_ack, misalign.
    logic [69:0] obs;
    logic [69:0] exp_v;
    assign obs = {pc_out, npc_out, state_out, annul_slot, trap_ack, misalign};

    pc_npc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .br_always   (br_always),
        .br_annul    (br_annul),
        .br_target   (br_target),
        .jmpl_valid  (jmpl_valid),
        .jmpl_target (jmpl_target),
        .trap_req    (trap_req),
        .trap_vec    (trap_vec),
        .pc_out      (pc_out),
        .npc_out     (npc_out),
        .annul_slot  (annul_slot),
        .trap_ack    (trap_ack),
        .misalign    (misalign),
        .state_out   (state_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers
    task automatic clear_inputs();
        reset = 0; advance = 0; br_valid = 0; br_taken = 0; br_always = 0;
        br_annul = 0; br_target = 32'h0; jmpl_valid = 0; jmpl_target = 32'h0;
        trap_req = 0; trap_vec = 32'h0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic adv();
        advance = 1;
        cycle();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; advance = 1; trap_req = 1; trap_vec = 32'h500;
        cycle();
        clear_inputs();
        exp_v = {32'h0, 32'h4, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset got %h want %h", obs, exp_v); end
    endtask

    task automatic test_sequential();
        do_reset();
        adv();
        exp_v = {32'h4, 32'h8, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL seq1 got %h want %h", obs, exp_v); end
        adv();
        exp_v = {32'h8, 32'hC, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL seq2 got %h want %h", obs, exp_v); end
        adv();
        exp_v = {32'hC, 32'h10, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL seq3 got %h want %h", obs, exp_v); end
        cycle();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL seq_hold got %h want %h", obs, exp_v); end
    endtask

    task automatic test_branch_taken();
        do_reset(); adv(); adv();
        advance = 1; br_valid = 1; br_taken = 1; br_target = 32'h40;
        cycle(); clear_inputs();
        exp_v = {32'hC, 32'h40, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL br_taken got %h want %h", obs, exp_v); end
        adv();
        exp_v = {32'h40, 32'h44, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL br_taken_next got %h want %h", obs, exp_v); end
        // Conditional taken with annul bit: delay slot executes.
        advance = 1; br_valid = 1; br_taken = 1; br_annul = 1; br_target = 32'h20;
        cycle(); clear_inputs();
        exp_v = {32'h44, 32'h20, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL br_taken_annul got %h want %h", obs, exp_v); end
    endtask

    task automatic test_not_taken_annul();
        do_reset(); adv(); adv();
        advance = 1; br_valid = 1; br_annul = 1; br_target = 32'h40;
        cycle(); clear_inputs();
        exp_v = {32'hC, 32'h10, 2'd1, 1'b1, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL nt_annul got %h want %h", obs, exp_v); end
        cycle();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL annul_hold got %h want %h", obs, exp_v); end
        advance = 1; br_valid = 1; br_taken = 1; br_target = 32'h80; jmpl_valid = 1; jmpl_target = 32'h200;
        cycle(); clear_inputs();
        exp_v = {32'h10, 32'h14, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL annul_step got %h want %h", obs, exp_v); end
    endtask

    task automatic test_ba_annul();
        do_reset();
        advance = 1; br_valid = 1; br_always = 1; br_annul = 1; br_target = 32'h100;
        cycle(); clear_inputs();
        exp_v = {32'h4, 32'h100, 2'd1, 1'b1, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL ba_annul got %h want %h", obs, exp_v); end
        adv();
        exp_v = {32'h100, 32'h104, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL ba_annul_next got %h want %h", obs, exp_v); end
    endtask

    task automatic test_jmpl_priority();
        do_reset();
        advance = 1; jmpl_valid = 1; jmpl_target = 32'h200; br_valid = 1; br_taken = 1; br_target = 32'h40;
        cycle(); clear_inputs();
        exp_v = {32'h4, 32'h200, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL jmpl_wins got %h want %h", obs, exp_v); end
    endtask

    task automatic test_misalign_trap();
        do_reset();
        advance = 1; jmpl_valid = 1; jmpl_target = 32'h102;
        cycle(); clear_inputs();
        exp_v = {32'h0, 32'h4, 2'd3, 1'b0, 1'b0, 1'b1};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL jmpl_halt got %h want %h", obs, exp_v); end
        for (int i = 0; i < 5; i++) begin
            advance = 1; br_valid = 1; br_taken = 1; br_target = 32'h40; jmpl_valid = 1; jmpl_target = 32'h300;
            cycle(); clear_inputs();
        end
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL halt_frozen got %h want %h", obs, exp_v); end
        trap_req = 1; trap_vec = 32'h800;
        cycle(); clear_inputs();
        exp_v = {32'h800, 32'h804, 2'd2, 1'b0, 1'b1, 1'b1};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL halt_trap got %h want %h", obs, exp_v); end
        cycle();
        exp_v = {32'h800, 32'h804, 2'd0, 1'b0, 1'b0, 1'b1};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL trap_return got %h want %h", obs, exp_v); end
        adv();
        exp_v = {32'h804, 32'h808, 2'd0, 1'b0, 1'b0, 1'b1};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL mis_sticky got %h want %h", obs, exp_v); end
        // Misaligned taken branch target also halts.
        do_reset();
        advance = 1; br_valid = 1; br_taken = 1; br_annul = 1; br_target = 32'h41;
        cycle(); clear_inputs();
        exp_v = {32'h0, 32'h4, 2'd3, 1'b0, 1'b0, 1'b1};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL br_misalign got %h want %h", obs, exp_v); end
    endtask

    task automatic test_trap_priority();
        do_reset();
        advance = 1; trap_req = 1; trap_vec = 32'h900; jmpl_valid = 1; jmpl_target = 32'h200;
        cycle();
        exp_v = {32'h900, 32'h904, 2'd2, 1'b0, 1'b1, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL trap_wins got %h want %h", obs, exp_v); end
        // Still requesting: TRAP ignores inputs and returns to RUN unchanged.
        trap_vec = 32'hA00;
        cycle(); clear_inputs();
        exp_v = {32'h900, 32'h904, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL trap_one_cycle got %h want %h", obs, exp_v); end
    endtask

    task automatic test_wrap();
        do_reset();
        trap_req = 1; trap_vec = 32'hFFFF_FFF8;
        cycle(); clear_inputs();
        cycle();
        exp_v = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrap_setup got %h want %h", obs, exp_v); end
        adv();
        exp_v = {32'hFFFF_FFFC, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL npc_wrap got %h want %h", obs, exp_v); end
        trap_req = 1; trap_vec = 32'hFFFF_FFFC;
        cycle(); clear_inputs();
        exp_v = {32'hFFFF_FFFC, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL vec_wrap got %h want %h", obs, exp_v); end
        cycle();
    endtask

    task automatic test_reset_in_annul();
        do_reset();
        advance = 1; br_valid = 1; br_annul = 1; br_target = 32'h40;
        cycle(); clear_inputs();
        exp_v = {32'h4, 32'h8, 2'd1, 1'b1, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL annul_setup got %h want %h", obs, exp_v); end
        reset = 1; advance = 1; trap_req = 1; trap_vec = 32'h700;
        cycle(); clear_inputs();
        exp_v = {32'h0, 32'h4, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_in_annul got %h want %h", obs, exp_v); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch_taken();
        test_not_taken_annul();
        test_ba_annul();
        test_jmpl_priority();
        test_misalign_trap();
        test_trap_priority();
        test_wrap();
        test_reset_in_annul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_npc_sequencer.md
Name: pc_npc_sequencer

Overview:
- Consumer side of the nPC register: holds the architectural PC/nPC pair and advances it every instruction.
- Implements SPARC delayed-control-transfer semantics: sequential step, taken/untaken branch with annul bit, jmpl, trap entry, misaligned-target halt.
- Sits between the control unit (branch/trap decisions) and the instruction-fetch address mux.
- Drives the PC used for fetch and the nPC fed back to the datapath.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- RESET_NPC, 32'h00000004, nPC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- advance  in  1  current instruction retires; allows the pair to step.
- br_valid  in  1  current instruction is a Bicc.
- br_taken  in  1  branch condition true (only meaningful with br_valid).
- br_always  in  1  branch is BA (unconditional).
- br_annul  in  1  instruction a-bit.
- br_target  in  32  branch target (PC + disp, already computed).
- jmpl_valid  in  1  current instruction is jmpl.
- jmpl_target  in  32  jmpl target.
- trap_req  in  1  trap request (level).
- trap_vec  in  32  trap handler address.
- pc_out  out  32  current PC.
- npc_out  out  32  current nPC.
- annul_slot  out  1  instruction at pc_out is annulled; fetch it but squash it.
- trap_ack  out  1  high for exactly one cycle, in the TRAP state.
- misalign  out  1  sticky misaligned-target flag.
- state_out  out  2  RUN=0, ANNUL=1, TRAP=2, HALT=3.

Behaviour:
- Reset (synchronous, highest priority, overrides any in-flight event):
  - pc_out=RESET_PC, npc_out=RESET_NPC, state=RUN.
  - annul_slot=0, trap_ack=0, misalign=0.
- Arithmetic: nPC+4 and trap_vec+4 are 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0. No flag is raised on wrap.
- Priority per cycle: reset > trap_req > jmpl_valid > br_valid > sequential.
- RUN, trap_req=1 (advance ignored):
  - pc<=trap_vec, npc<=trap_vec+4.
  - Next state TRAP.
- RUN, advance=0, no trap: hold all state.
- RUN, advance=1, jmpl_valid:
  - If jmpl_target[1:0]!=0: go to HALT, misalign<=1, pc/npc unchanged.
  - Otherwise: pc<=npc, npc<=jmpl_target.
- RUN, advance=1, br_valid:
  - Effective taken = br_taken | br_always.
  - Taken: pc<=npc, npc<=br_target. If br_target[1:0]!=0, go to HALT instead and leave pc/npc unchanged.
  - Not taken: pc<=npc, npc<=npc+4.
  - Annul: next state ANNUL when br_annul && (!taken || br_always); otherwise RUN.
- RUN, advance=1, no event: pc<=npc, npc<=npc+4.
- ANNUL:
  - annul_slot=1 (registered, asserted combinationally from state).
  - On advance: sequential step only, with pc<=npc, npc<=npc+4; br_valid and jmpl_valid are ignored; return to RUN.
  - trap_req still has priority and goes to TRAP.
  - advance=0: hold.
- TRAP:
  - trap_ack=1; one cycle only; unconditional return to RUN.
  - Inputs are ignored except reset.
- HALT:
  - pc/npc frozen; misalign=1.
  - advance, branch and jmpl inputs are ignored.
  - Exits only via reset (to RUN) or trap_req (to TRAP).
  - misalign stays set until reset.
- Latency: every update is visible on pc_out/npc_out the cycle after the triggering edge. No combinational path from inputs to pc_out/npc_out.
- Simultaneous events:
  - br_valid and jmpl_valid both high: jmpl wins.
  - trap_req with advance: trap wins and the instruction does not retire.

Test Plan:
- Reset, then 3 advances -> pc/npc = 0/4, 4/8, 8/C, C/10; annul_slot=0 throughout.
- At pc=8/npc=C, br_valid=1, br_taken=1, br_target=0x40, annul=0 -> pc=C, npc=40. Next advance -> pc=40, npc=44; state stays RUN.
- At pc=8/npc=C, conditional branch not taken with annul=1 -> pc=C, npc=10, state ANNUL, annul_slot=1. Next advance with br_valid=1 (must be ignored) -> pc=10, npc=14, RUN.
- BA with annul=1, target 0x100, from pc=0/npc=4 -> pc=4, npc=100, annul_slot=1. Next advance -> pc=100, npc=104.
- jmpl_target=0x102 -> state HALT, misalign=1, pc/npc unchanged across 5 advances. trap_req with trap_vec=0x800 -> pc=800, npc=804, trap_ack pulses one cycle, then RUN; misalign stays 1.
- npc=FFFFFFFC, advance -> npc=0. Separately, assert reset while in ANNUL -> next cycle pc=0, npc=4, RUN, annul_slot=0.
